prog_sequencer: RTL

- Autonomous instruction feeder for the 8-register bus processor `proc`.
- Fetches instruction words from a small synchronous program memory and presents them on the processor's DIN with a Run pulse.
- For mvi, supplies the immediate word on DIN during the processor's load step, then waits for Done before advancing.
- Sits between program memory and `proc`, so a program runs without a testbench driving DIN/Run by hand.

---
 rtl/prog_sequencer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer
// ---------------------------------------------------------------------------
// Autonomous instruction feeder for the 8-register bus processor `proc`.
// Instruction words are fetched from a small synchronous program memory and
// handed to proc on DIN with a one-cycle Run pulse. For mvi (two words), the
// immediate word is fetched too and held on DIN during proc's load step. The
// sequencer then waits for Done before it moves to the next instruction.
//
// Instruction word: op = word[7:6] (00 mv, 01 mvi, 10 add, 11 sub),
//                   X = word[5:3], Y = word[2:0] (interpreted by proc only).
//
// Parameters
//   ADDR_W   program memory address width (depth 2**ADDR_W words)
//   TIMEOUT  cycles from the Run pulse until Error is raised if Done never
//            arrives
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (proc shares this net)
//   Start        begin execution at address 0 (only sampled when not Busy)
//   Halt         request a stop at the next instruction boundary
//   prog_len     number of program words, 0..2**ADDR_W
//   mem_addr     program memory address
//   mem_rd       memory read strobe; mem_data is valid the following cycle
//   mem_data     program memory read data
//   proc_DIN     data to proc (0 whenever the sequencer is not driving it)
//   proc_Run     one-cycle Run pulse to proc
//   proc_Done    Done from proc
//   pc           address of the next instruction word
//   instr_count  instructions completed since Start, saturating at 255
//   Busy         high in every state except IDLE / STOPPED / ERR
//   Finished     high in STOPPED
//   Error        high in ERR (Done did not arrive in time)
//   pass_count   (PROG_SEQ_LOOP_EN only) number of wraps back to address 0
//
// Build option
//   PROG_SEQ_LOOP_EN  when defined, reaching the end of the program wraps pc
//                     back to 0 and execution continues; pass_count counts
//                     the wraps and Halt is the only way out. When it is
//                     undefined, the end of the program goes to STOPPED.
// ---------------------------------------------------------------------------
module prog_sequencer #(
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic              Halt,
   input  logic [ADDR_W:0]   prog_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic [7:0]        proc_DIN,
   output logic              proc_Run,
   input  logic              proc_Done,
   output logic [ADDR_W:0]   pc,
   output logic [7:0]        instr_count,
   output logic              Busy,
   output logic              Finished,
   output logic              Error
`ifdef PROG_SEQ_LOOP_EN
   ,
   output logic [7:0]        pass_count
`endif
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_STOPPED,
      S_ERR,
      S_FETCH,
      S_FWAIT,
      S_IFETCH,
      S_IWAIT,
      S_ISSUE,
      S_EXEC
   } state_t;

   localparam logic [1:0] OP_MVI = 2'b01;

   // The timeout counter is cleared in ISSUE and counts EXEC cycles. The
   // Run cycle and the cycle in which ERR is entered both count toward
   // TIMEOUT, so ERR is entered after the EXEC cycle in which the counter
   // equals TIMEOUT-2. Error therefore rises exactly TIMEOUT cycles after Run.
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   localparam logic [ADDR_W:0]   PC_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   PC_TWO   = (ADDR_W + 1)'(2);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state, state_nxt;
   logic [7:0]        ir_buf, ir_buf_nxt;
   logic [7:0]        imm_buf, imm_buf_nxt;
   logic              halt_req, halt_req_nxt;
   logic [TW-1:0]     tmo_cnt, tmo_cnt_nxt;
   logic [ADDR_W:0]   pc_nxt;
   logic [7:0]        instr_count_nxt;
`ifdef PROG_SEQ_LOOP_EN
   logic [7:0]        pass_count_nxt;
`endif

   logic              is_busy;
   logic              ir_is_mvi;
   logic [ADDR_W:0]   pc_new;
   logic              at_end;
   logic              halt_eff;
   logic [7:0]        count_inc;

   // ------------------------------------------------------------------
   // Helper decodes shared by the next-state logic and the outputs
   // ------------------------------------------------------------------
   always_comb begin
      is_busy   = !((state == S_IDLE) || (state == S_STOPPED) || (state == S_ERR));
      ir_is_mvi = (ir_buf[7:6] == OP_MVI);
      // mvi occupies two words, so pc moves past the immediate as well.
      pc_new    = pc + (ir_is_mvi ? PC_TWO : PC_ONE);
      at_end    = (pc_new >= prog_len);
      // A Halt arriving in the Done cycle itself is honoured at that boundary.
      halt_eff  = halt_req || Halt;
      count_inc = (instr_count == 8'hFF) ? instr_count : instr_count + 8'd1;
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= '0;
         instr_count <= '0;
         ir_buf      <= '0;
         imm_buf     <= '0;
         halt_req    <= 1'b0;
         tmo_cnt     <= '0;
`ifdef PROG_SEQ_LOOP_EN
         pass_count  <= '0;
`endif
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr_count <= instr_count_nxt;
         ir_buf      <= ir_buf_nxt;
         imm_buf     <= imm_buf_nxt;
         halt_req    <= halt_req_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
`ifdef PROG_SEQ_LOOP_EN
         pass_count  <= pass_count_nxt;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state and register update logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      instr_count_nxt = instr_count;
      ir_buf_nxt      = ir_buf;
      imm_buf_nxt     = imm_buf;
      halt_req_nxt    = halt_req;
      tmo_cnt_nxt     = tmo_cnt;
`ifdef PROG_SEQ_LOOP_EN
      pass_count_nxt  = pass_count;
`endif

      // Halt is only latched while running. It is acted on at the next
      // Done boundary, because proc cannot be aborted mid-step.
      if (is_busy && Halt) begin
         halt_req_nxt = 1'b1;
      end

      unique case (state)
         S_IDLE, S_STOPPED, S_ERR: begin
            // If Start and Halt arrive together here, Start wins.
            if (Start) begin
               pc_nxt          = '0;
               instr_count_nxt = '0;
               halt_req_nxt    = 1'b0;
`ifdef PROG_SEQ_LOOP_EN
               pass_count_nxt  = '0;
`endif
               state_nxt       = (prog_len == '0) ? S_STOPPED : S_FETCH;
            end
         end

         S_FETCH: begin
            state_nxt = S_FWAIT;
         end

         S_FWAIT: begin
            ir_buf_nxt = mem_data;
            state_nxt  = (mem_data[7:6] == OP_MVI) ? S_IFETCH : S_ISSUE;
         end

         S_IFETCH: begin
            state_nxt = S_IWAIT;
         end

         S_IWAIT: begin
            imm_buf_nxt = mem_data;
            state_nxt   = S_ISSUE;
         end

         S_ISSUE: begin
            tmo_cnt_nxt = '0;
            state_nxt   = S_EXEC;
         end

         S_EXEC: begin
            tmo_cnt_nxt = tmo_cnt + TMO_ONE;
            if (proc_Done) begin
               pc_nxt          = pc_new;
               instr_count_nxt = count_inc;
               if (halt_eff) begin
                  state_nxt = S_STOPPED;
               end else if (at_end) begin
`ifdef PROG_SEQ_LOOP_EN
                  pc_nxt         = '0;
                  pass_count_nxt = pass_count + 8'd1;
                  state_nxt      = S_FETCH;
`else
                  state_nxt      = S_STOPPED;
`endif
               end else begin
                  state_nxt = S_FETCH;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt = S_ERR;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from state and registered values only
   // ------------------------------------------------------------------
   always_comb begin
      mem_addr = '0;
      mem_rd   = 1'b0;
      proc_DIN = 8'h00;
      proc_Run = 1'b0;
      Busy     = is_busy;
      Finished = (state == S_STOPPED);
      Error    = (state == S_ERR);

      unique case (state)
         S_FETCH: begin
            mem_addr = pc[ADDR_W-1:0];
            mem_rd   = 1'b1;
         end
         S_IFETCH: begin
            // Wraps modulo the memory depth when mvi is the last word.
            mem_addr = pc[ADDR_W-1:0] + ADDR_ONE;
            mem_rd   = 1'b1;
         end
         S_ISSUE: begin
            proc_Run = 1'b1;
            proc_DIN = ir_buf;
         end
         S_EXEC: begin
            // proc loads the mvi immediate from DIN in its first step.
            proc_DIN = ir_is_mvi ? imm_buf : 8'h00;
         end
         default: begin
         end
      endcase
   end

endmodule
